// File: rtl/rotate_mask_halfword_pipe.sv
// Four-stage halfword right-shift unit for rothm / rotmah / rothmi / rotmahi.
// Each of the eight 16-bit lanes is shifted right by its own count.
// The count is the low five bits of the negated shift operand.
// Logical forms fill with zeros. Algebraic forms fill with the lane sign bit.
//
// Handshake: in_valid and out_valid qualify their cycle only. There is no
// ready signal in either direction: an instruction is accepted on every edge
// where in_valid = 1 and flush = 0, and its result is presented for exactly
// one cycle with out_valid = 1, LATENCY edges later, in issue order.
// register_RT and out_rt_tag keep the last presented result while
// out_valid = 0.
module rotate_mask_halfword_pipe #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic [127:0]       register_RA,
  input  logic [127:0]       register_RB,
  input  logic [6:0]         imm7,
  input  logic [TAG_W-1:0]   rt_tag,
  input  logic               flush,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_rt_tag,
  output logic [127:0]       register_RT
);

  // The stage split below is hard-wired to four register stages.
  if (LATENCY != 4) begin : g_latency_check
    $error("rotate_mask_halfword_pipe is built for LATENCY = 4 only");
  end

  // ---------------------------------------------------------------------------
  // Issue-side count and fill decode
  // ---------------------------------------------------------------------------
  // Only the low five bits of each negation are used as a shift count.
  logic [127:0] rb_neg;
  logic [15:0]  imm_neg;
  logic [39:0]  cnt_d;
  logic [7:0]   fill_d;
  logic         unused_neg;

  // The immediate is sign-extended to 16 bits before it is negated.
  assign imm_neg    = 16'h0000 - {{9{imm7[6]}}, imm7};
  assign unused_neg = ^{rb_neg, imm_neg};

  // Per-lane count: the immediate applies to every lane in op 10/11.
  // A lane's fill bit is set only for algebraic forms with a negative lane.
  always_comb begin
    rb_neg = '0;
    cnt_d  = '0;
    fill_d = '0;
    for (int h = 0; h < 8; h++) begin
      rb_neg[16*h +: 16] = 16'h0000 - register_RB[16*h +: 16];
      cnt_d[5*h +: 5]    = op[1] ? imm_neg[4:0] : rb_neg[16*h +: 5];
      fill_d[h]          = op[0] & register_RA[16*h + 15];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: operands, counts, fill bits
  // ---------------------------------------------------------------------------
  logic               s1_valid;
  logic [127:0]       s1_ra;
  logic [39:0]        s1_cnt;
  logic [7:0]         s1_fill;
  logic [TAG_W-1:0]   s1_tag;

  // Stage 1 valid: flush and reset both squash the instruction issued this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid & ~flush;
    end
  end

  // Stage 1 data loads only for an issued instruction.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_ra   <= register_RA;
      s1_cnt  <= cnt_d;
      s1_fill <= fill_d;
      s1_tag  <= rt_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: coarse shift (saturate at 16, else shift by 8)
  // ---------------------------------------------------------------------------
  logic [127:0] coarse_d;
  logic [23:0]  fine_cnt_d;

  // Count bit 4 means 16 or more, so the whole lane becomes fill.
  // Bit 3 moves the upper byte down. The low three count bits go forward.
  always_comb begin
    coarse_d   = '0;
    fine_cnt_d = '0;
    for (int h = 0; h < 8; h++) begin
      if (s1_cnt[5*h + 4]) begin
        coarse_d[16*h +: 16] = {16{s1_fill[h]}};
      end else if (s1_cnt[5*h + 3]) begin
        coarse_d[16*h +: 16] = {{8{s1_fill[h]}}, s1_ra[16*h + 8 +: 8]};
      end else begin
        coarse_d[16*h +: 16] = s1_ra[16*h +: 16];
      end
      fine_cnt_d[3*h +: 3] = s1_cnt[5*h +: 3];
    end
  end

  logic               s2_valid;
  logic [127:0]       s2_data;
  logic [23:0]        s2_fine;
  logic [7:0]         s2_fill;
  logic [TAG_W-1:0]   s2_tag;

  // Stage 2 valid advances from stage 1 unless it is squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~flush;
    end
  end

  // Stage 2 data loads only when stage 1 holds a valid instruction.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_data <= coarse_d;
      s2_fine <= fine_cnt_d;
      s2_fill <= s1_fill;
      s2_tag  <= s1_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: fine shift (by 1, then 2, then 4)
  // ---------------------------------------------------------------------------
  logic [127:0] step1_d;
  logic [127:0] step2_d;
  logic [127:0] fine_d;

  // Three conditional shifts per lane, each filling from the lane's own fill bit.
  // A saturated lane is already all fill, so further shifting leaves it unchanged.
  always_comb begin
    step1_d = '0;
    step2_d = '0;
    fine_d  = '0;
    for (int h = 0; h < 8; h++) begin
      step1_d[16*h +: 16] = s2_fine[3*h]
                          ? {s2_fill[h], s2_data[16*h + 1 +: 15]}
                          : s2_data[16*h +: 16];
      step2_d[16*h +: 16] = s2_fine[3*h + 1]
                          ? {{2{s2_fill[h]}}, step1_d[16*h + 2 +: 14]}
                          : step1_d[16*h +: 16];
      fine_d[16*h +: 16]  = s2_fine[3*h + 2]
                          ? {{4{s2_fill[h]}}, step2_d[16*h + 4 +: 12]}
                          : step2_d[16*h +: 16];
    end
  end

  logic               s3_valid;
  logic [127:0]       s3_data;
  logic [TAG_W-1:0]   s3_tag;

  // Stage 3 valid advances from stage 2 unless it is squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid <= 1'b0;
    end else begin
      s3_valid <= s2_valid & ~flush;
    end
  end

  // Stage 3 data loads only when stage 2 holds a valid instruction.
  always_ff @(posedge clk) begin
    if (s2_valid) begin
      s3_data <= fine_d;
      s3_tag  <= s2_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: output register
  // ---------------------------------------------------------------------------
  // A result squashed by flush is never presented, so the outputs keep the
  // previous result. Reset clears both valid and the visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_rt_tag  <= '0;
      register_RT <= '0;
    end else begin
      out_valid <= s3_valid & ~flush;
      if (s3_valid && !flush) begin
        out_rt_tag  <= s3_tag;
        register_RT <= s3_data;
      end
    end
  end

endmodule
